// File: rtl/genie_pkt_fifo.sv
// rtl/genie_pkt_fifo.sv - elastic valid/ready/eop packet FIFO (store-and-forward via GENIE_PKT_FIFO_STORE_FWD_EN)
module genie_pkt_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic                       i_eop,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic                       o_eop,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          wr_en;
  logic          rd_en;
  logic          eop_mem [DEPTH];

  // Ready comes only from registered occupancy, gated low while reset is held.
  assign o_ready = reset_n && (count != FULL_CNT);
  assign wr_en   = i_valid && o_ready;
  assign rd_en   = o_valid && i_ready;
  assign o_count = count;
  assign o_eop   = eop_mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two; count tracks occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
      case ({wr_en, rd_en})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Eop storage is deliberately not reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) eop_mem[wr_ptr] <= i_eop;
  end

  generate
    if (WIDTH > 0) begin : g_data
      logic [WIDTH-1:0] data_mem [DEPTH];
      // Data storage written alongside eop; head read out fall-through style.
      always_ff @(posedge clk) begin
        if (wr_en) data_mem[wr_ptr] <= i_data;
      end
      assign o_data = data_mem[rd_ptr];
    end else begin : g_nodata
      assign o_data = '0;
    end
  endgenerate

`ifdef GENIE_PKT_FIFO_STORE_FWD_EN
  logic [CW-1:0] pkt_count;

  // Number of complete packets held; a full buffer also releases output so long packets cannot deadlock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pkt_count <= '0;
    end else begin
      case ({wr_en && i_eop, rd_en && o_eop})
        2'b10:   pkt_count <= pkt_count + CNT_ONE;
        2'b01:   pkt_count <= pkt_count - CNT_ONE;
        default: pkt_count <= pkt_count;
      endcase
    end
  end

  assign o_valid = (count != '0) && ((pkt_count != '0) || (count == FULL_CNT));
`else
  assign o_valid = (count != '0);
`endif

endmodule
